// File: rtl/cache_dm_pkg.sv
// Shared types, constants and width helpers for the direct-mapped read-only cache.
package cache_dm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FILL   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [31:0] BACKING_XOR = 32'hDEAD_BEEF;

   function automatic int index_width(input int num_lines);
      return $clog2(num_lines);
   endfunction

   // Everything above the word offset and the index is tag.
   function automatic int tag_width(input int addr_w, input int num_lines);
      return addr_w - $clog2(num_lines) - 2;
   endfunction

endpackage

// File: rtl/cache_dm_if.sv
// CPU-side AXI4-lite read subset (AR and R channels) between a load path and the cache.
interface cache_dm_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] cpu_ar_addr;
   logic              cpu_ar_valid;
   logic              cpu_ar_ready;
   logic [DATA_W-1:0] cpu_r_data;
   logic [1:0]        cpu_r_resp;
   logic              cpu_r_valid;
   logic              cpu_r_ready;

   modport master (
      output cpu_ar_addr, cpu_ar_valid, cpu_r_ready,
      input  cpu_ar_ready, cpu_r_data, cpu_r_resp, cpu_r_valid
   );

   modport slave (
      input  cpu_ar_addr, cpu_ar_valid, cpu_r_ready,
      output cpu_ar_ready, cpu_r_data, cpu_r_resp, cpu_r_valid
   );
endinterface

// File: rtl/cache_dm_backing.sv
// Fixed-latency backing memory model: data is a pure function of the word address,
// done is raised on the MISS_LATENCY-th cycle after start.
module cache_dm_backing
   import cache_dm_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MISS_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:2] addr_i,
   output logic              done_o,
   output logic [DATA_W-1:0] data_o
);
   localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

   logic              busy_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:2] addr_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         addr_q <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         addr_q <= addr_i;
      end else if (done_o) begin
         busy_q <= 1'b0;
      end else if (busy_q) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign done_o = busy_q && (cnt_q == CNT_W'(MISS_LATENCY - 1));
   assign data_o = DATA_W'({addr_q, 2'b00}) ^ DATA_W'(BACKING_XOR);

endmodule

// File: rtl/cache_dm.sv
// Direct-mapped, read-only, one-word-per-line cache with a single outstanding
// AXI4-lite read; misses are filled from the fixed-latency backing model.
module cache_dm
   import cache_dm_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int NUM_LINES    = 16,
   parameter int MISS_LATENCY = 2
) (
   input  logic      clk,
   input  logic      rst,
   cache_dm_if.slave cpu
);
   localparam int INDEX_W = index_width(NUM_LINES);
   localparam int TAG_W   = tag_width(ADDR_W, NUM_LINES);

   state_e            state_q, state_d;
   logic [ADDR_W-1:2] addr_q, addr_d;
   logic [DATA_W-1:0] r_data_q, r_data_d;

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [DATA_W-1:0]    data_q [NUM_LINES];

   logic [INDEX_W-1:0] lookup_idx;
   logic [TAG_W-1:0]   lookup_tag;
   logic               hit;
   logic               fill_start;
   logic               fill_we;
   logic               fill_done;
   logic [DATA_W-1:0]  fill_data;

   assign lookup_idx = addr_q[INDEX_W+1:2];
   assign lookup_tag = addr_q[ADDR_W-1:INDEX_W+2];
   assign hit        = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

   cache_dm_backing #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .MISS_LATENCY (MISS_LATENCY)
   ) u_backing (
      .clk     (clk),
      .rst     (rst),
      .start_i (fill_start),
      .addr_i  (addr_q),
      .done_o  (fill_done),
      .data_o  (fill_data)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      r_data_d   = r_data_q;
      fill_start = 1'b0;
      fill_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu.cpu_ar_valid) begin
               addr_d  = cpu.cpu_ar_addr[ADDR_W-1:2];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            // Array data only reaches r_data behind a set valid bit.
            if (hit) begin
               r_data_d = data_q[lookup_idx];
               state_d  = RESP;
            end else begin
               fill_start = 1'b1;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (fill_done) begin
               fill_we  = 1'b1;
               r_data_d = fill_data;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (cpu.cpu_r_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         r_data_q <= '0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         r_data_q <= r_data_d;
         if (fill_we) valid_q[lookup_idx] <= 1'b1;
      end
   end

   // NOTE: tag/data arrays are deliberately not reset; the reset valid bits make them unobservable.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[lookup_idx]  <= lookup_tag;
         data_q[lookup_idx] <= fill_data;
      end
   end

   assign cpu.cpu_ar_ready = (state_q == IDLE);
   assign cpu.cpu_r_valid  = (state_q == RESP);
   assign cpu.cpu_r_data   = r_data_q;
   assign cpu.cpu_r_resp   = RESP_OKAY;

endmodule

// File: tb/tb_cache_dm.sv
// Directed bench for cache_dm: a table of reads with hand-computed data and hit/miss
// latency, plus sequences for backpressure and reset during a fill.
module tb_cache_dm;

   localparam int ML       = 2;
   localparam int LAT_HIT  = 2;       // edges counted from and including the AR edge
   localparam int LAT_MISS = 2 + ML;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int total = 0;
   int bad   = 0;

   cache_dm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   cache_dm #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .NUM_LINES    (16),
      .MISS_LATENCY (ML)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cpu (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        hit;
      logic [31:0] data;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one read with r_ready held high; checks latency, data, resp and post-handshake state.
   task automatic do_read(input string name, input logic [31:0] addr,
                          input int exp_lat, input logic [31:0] exp_data);
      int lat;
      check({name, " ar_ready idle"}, 32'(bus.cpu_ar_ready), 32'd1);
      bus.cpu_ar_addr  = addr;
      bus.cpu_ar_valid = 1'b1;
      bus.cpu_r_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cpu_ar_valid = 1'b0;
      lat = 1;
      while (!bus.cpu_r_valid && lat < 50) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      if (!bus.cpu_r_valid) return;
      check({name, " r_data"}, bus.cpu_r_data, exp_data);
      check({name, " r_resp"}, 32'(bus.cpu_r_resp), 32'd0);
      check({name, " ar_ready busy"}, 32'(bus.cpu_ar_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({name, " r_valid drop"}, 32'(bus.cpu_r_valid), 32'd0);
      check({name, " r_data held"}, bus.cpu_r_data, exp_data);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{addr: 32'h0000_0040, hit: 1'b0, data: 32'hDEAD_BEAF}; // cold miss
      vecs[1] = '{addr: 32'h0000_0040, hit: 1'b1, data: 32'hDEAD_BEAF}; // hit
      vecs[2] = '{addr: 32'h0000_0080, hit: 1'b0, data: 32'hDEAD_BE6F}; // evicts 0x40
      vecs[3] = '{addr: 32'h0000_0040, hit: 1'b0, data: 32'hDEAD_BEAF}; // misses again
      vecs[4] = '{addr: 32'h0000_0043, hit: 1'b1, data: 32'hDEAD_BEAF}; // unaligned, same line
      vecs[5] = '{addr: 32'h0000_0044, hit: 1'b0, data: 32'hDEAD_BEAB};
      vecs[6] = '{addr: 32'h1000_0044, hit: 1'b0, data: 32'hCEAD_BEAB}; // same index, high tag bit
      vecs[7] = '{addr: 32'h0000_0047, hit: 1'b0, data: 32'hDEAD_BEAB};
      vecs[8] = '{addr: 32'h0000_003C, hit: 1'b0, data: 32'hDEAD_BED3}; // last index
      vecs[9] = '{addr: 32'h0000_003C, hit: 1'b1, data: 32'hDEAD_BED3};

      bus.cpu_ar_addr  = '0;
      bus.cpu_ar_valid = 1'b0;
      bus.cpu_r_ready  = 1'b0;

      repeat (2) @(negedge clk);
      check("reset ar_ready", 32'(bus.cpu_ar_ready), 32'd1);
      check("reset r_valid",  32'(bus.cpu_r_valid),  32'd0);
      check("reset r_data",   bus.cpu_r_data,        32'd0);
      check("reset r_resp",   32'(bus.cpu_r_resp),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         do_read($sformatf("vec%0d", i), vecs[i].addr,
                 vecs[i].hit ? LAT_HIT : LAT_MISS, vecs[i].data);
      end

      // Backpressure: hold r_ready low in RESP while a competing AR is offered.
      bus.cpu_r_ready  = 1'b0;
      bus.cpu_ar_addr  = 32'h0000_0040;
      bus.cpu_ar_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cpu_ar_addr = 32'h0000_0080;
      @(posedge clk);
      @(negedge clk);
      check("bp r_valid rise", 32'(bus.cpu_r_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp r_valid c%0d", c),  32'(bus.cpu_r_valid),  32'd1);
         check($sformatf("bp r_data c%0d", c),   bus.cpu_r_data,        32'hDEAD_BEAF);
         check($sformatf("bp ar_ready c%0d", c), 32'(bus.cpu_ar_ready), 32'd0);
      end
      bus.cpu_ar_valid = 1'b0;
      bus.cpu_r_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp ar_ready after", 32'(bus.cpu_ar_ready), 32'd1);
      check("bp r_valid after",  32'(bus.cpu_r_valid),  32'd0);
      do_read("bp line kept", 32'h0000_0040, LAT_HIT, 32'hDEAD_BEAF);

      // Reset in the middle of a fill drops the request and invalidates every line.
      bus.cpu_ar_addr  = 32'h0000_0084;
      bus.cpu_ar_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cpu_ar_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst async ar_ready", 32'(bus.cpu_ar_ready), 32'd1);
      check("rst async r_valid",  32'(bus.cpu_r_valid),  32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post rst ar_ready", 32'(bus.cpu_ar_ready), 32'd1);
      check("post rst r_valid",  32'(bus.cpu_r_valid),  32'd0);
      do_read("post rst 0x40", 32'h0000_0040, LAT_MISS, 32'hDEAD_BEAF);
      do_read("post rst 0x3C", 32'h0000_003C, LAT_MISS, 32'hDEAD_BED3);
      do_read("refill hit",    32'h0000_0043, LAT_HIT,  32'hDEAD_BEAF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
